// File: rtl/ast_packet_gen_if.sv
// Avalon-ST streaming interface used by the packet generator source port.
interface avalon_st_if #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1
);
    localparam int BYTES   = DWIDTH / 8;
    localparam int EMPTY_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DWIDTH-1:0]        data;
    logic                     valid;
    logic                     startofpacket;
    logic                     endofpacket;
    logic [EMPTY_W-1:0]       empty;
    logic [CHANNEL_WIDTH-1:0] channel;
    logic                     ready;

    modport src (output data, valid, startofpacket, endofpacket, empty, channel,
                 input  ready);
    modport snk (input  data, valid, startofpacket, endofpacket, empty, channel,
                 output ready);
endinterface

// File: rtl/ast_packet_gen.sv
// Avalon-ST packet generator: one incrementing-payload packet per start pulse.
// Optional build macro PKT_GEN_THROTTLE_EN inserts a valid gap after every accepted beat.
//
// state | meaning
// IDLE  | waiting for start_i; len==0 pulses err_o
// SEND  | presenting beats, advancing on valid & ready
// DONE  | one-cycle done_o pulse, busy_o already low
module ast_packet_gen #(
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     start_i,
    input  logic [LEN_WIDTH-1:0]     pkt_len_i,
    input  logic [7:0]               seed_i,
    input  logic [CHANNEL_WIDTH-1:0] channel_i,
    input  logic                     key_en_i,
    input  logic [LEN_WIDTH-1:0]     key_beat_i,
    input  logic [AST_DWIDTH-1:0]    key_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    avalon_st_if.src                 ast_src_if
);
    localparam int BYTES   = AST_DWIDTH / 8;
    localparam int EMPTY_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LEN_WIDTH:0]   BYTES_L = (LEN_WIDTH+1)'(BYTES);
    localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                   state;
    logic [LEN_WIDTH-1:0]     len_q, key_beat_q, beat_cnt;
    logic [LEN_WIDTH:0]       base_q;
    logic [7:0]               seed_q;
    logic                     key_en_q;
    logic [AST_DWIDTH-1:0]    key_q;
    logic                     valid_q, sop_q, eop_q;
    logic [AST_DWIDTH-1:0]    data_q;
    logic [EMPTY_W-1:0]       empty_q;
    logic [CHANNEL_WIDTH-1:0] channel_q;
`ifdef PKT_GEN_THROTTLE_EN
    logic                     gap_q;
`endif

    logic [LEN_WIDTH-1:0]     sel_len, sel_key_beat, nb_idx;
    logic [7:0]               sel_seed;
    logic                     sel_key_en, nb_eop;
    logic [AST_DWIDTH-1:0]    sel_key, nb_data;
    logic [LEN_WIDTH:0]       nb_base, nb_end, byte_n;
    logic [EMPTY_W-1:0]       nb_empty;

    // Next beat contents: in IDLE built from the live inputs (beat 0), else from latched fields.
    always_comb begin
        if (state == IDLE) begin
            sel_len      = pkt_len_i;
            sel_seed     = seed_i;
            sel_key_en   = key_en_i;
            sel_key_beat = key_beat_i;
            sel_key      = key_i;
            nb_base      = '0;
            nb_idx       = '0;
        end else begin
            sel_len      = len_q;
            sel_seed     = seed_q;
            sel_key_en   = key_en_q;
            sel_key_beat = key_beat_q;
            sel_key      = key_q;
            nb_base      = base_q + BYTES_L;
            nb_idx       = beat_cnt + ONE_L;
        end
        nb_end  = nb_base + BYTES_L;
        nb_data = '0;
        byte_n  = '0;
        for (int i = 0; i < BYTES; i++) begin
            byte_n = nb_base + (LEN_WIDTH+1)'(i);
            if (byte_n < {1'b0, sel_len})
                nb_data[AST_DWIDTH-1-8*i -: 8] = sel_seed + byte_n[7:0];
        end
        if (sel_key_en && (sel_key_beat == nb_idx))
            nb_data = sel_key;
        nb_eop   = (nb_end >= {1'b0, sel_len});
        nb_empty = nb_eop ? EMPTY_W'(nb_end - {1'b0, sel_len}) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state      <= IDLE;
            len_q      <= '0;
            key_beat_q <= '0;
            beat_cnt   <= '0;
            base_q     <= '0;
            seed_q     <= '0;
            key_en_q   <= 1'b0;
            key_q      <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
            empty_q    <= '0;
            channel_q  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
`ifdef PKT_GEN_THROTTLE_EN
            gap_q      <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (pkt_len_i == '0) begin
                            err_o <= 1'b1;
                        end else begin
                            len_q      <= pkt_len_i;
                            seed_q     <= seed_i;
                            channel_q  <= channel_i;
                            key_en_q   <= key_en_i;
                            key_beat_q <= key_beat_i;
                            key_q      <= key_i;
                            beat_cnt   <= '0;
                            base_q     <= '0;
                            valid_q    <= 1'b1;
                            data_q     <= nb_data;
                            sop_q      <= 1'b1;
                            eop_q      <= nb_eop;
                            empty_q    <= nb_empty;
                            busy_o     <= 1'b1;
                            state      <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (valid_q && ast_src_if.ready && eop_q) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        sop_q   <= 1'b0;
                        eop_q   <= 1'b0;
                        empty_q <= '0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state   <= DONE;
`ifdef PKT_GEN_THROTTLE_EN
                    end else if (gap_q) begin
                        gap_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        data_q   <= nb_data;
                        sop_q    <= 1'b0;
                        eop_q    <= nb_eop;
                        empty_q  <= nb_empty;
                        beat_cnt <= nb_idx;
                        base_q   <= nb_base;
                    end else if (valid_q && ast_src_if.ready) begin
                        // Hold the accepted beat's fields through the gap cycle.
                        valid_q <= 1'b0;
                        gap_q   <= 1'b1;
                    end
`else
                    end else if (valid_q && ast_src_if.ready) begin
                        data_q   <= nb_data;
                        sop_q    <= 1'b0;
                        eop_q    <= nb_eop;
                        empty_q  <= nb_empty;
                        beat_cnt <= nb_idx;
                        base_q   <= nb_base;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ast_src_if.data          = data_q;
    assign ast_src_if.valid         = valid_q;
    assign ast_src_if.startofpacket = sop_q;
    assign ast_src_if.endofpacket   = eop_q;
    assign ast_src_if.empty         = empty_q;
    assign ast_src_if.channel       = channel_q;
endmodule
